// File: rtl/sha256_pad_feed.sv
// SHA-256 padding front end: buffers a 32-bit big-endian word stream into 512-bit blocks,
// appends marker/zero/length padding and sweeps each block out as a 64-slot w_cnt schedule.
module sha256_pad_feed #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_data,
    input  logic        m_last,
    input  logic [1:0]  m_bytes,
    input  logic        hash_done,
    output logic        w_vld,
    output logic [5:0]  w_cnt,
    output logic [31:0] w_data,
    output logic        blk_first,
    output logic        busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_PAD  = 3'd2;
    localparam logic [2:0] S_SEND = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [3:0]        widx_q, widx_d;
    logic [LEN_W-1:0]  bitcnt_q, bitcnt_d;
    logic              first_q, first_d;
    logic              done_q, done_d;
    logic              extra_q, extra_d;
    logic              mpend_q, mpend_d;
    logic              final_q, final_d;
    logic [WORD_W-1:0] wbuf_q [NWORDS];
    logic [WORD_W-1:0] wbuf_d [NWORDS];

    logic              m_ready_q, m_ready_d;
    logic              w_vld_q, w_vld_d;
    logic [5:0]        w_cnt_q, w_cnt_d;
    logic [WORD_W-1:0] w_data_q, w_data_d;
    logic              blk_first_q, blk_first_d;
    logic              busy_q, busy_d;

    logic              xfer;
    logic [WORD_W-1:0] last_word;
    logic [5:0]        amt;
    logic [63:0]       len64;
    logic [WORD_W-1:0] pad_word;

    // Last-word trimming, bit-count increment and padding word for the current index
    always_comb begin
        xfer = m_valid & m_ready_q;
        case (m_bytes)
            2'd1:    last_word = {m_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {m_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {m_data[31:8], 8'h80};
            default: last_word = m_data;
        endcase
        amt = (m_last && (m_bytes != 2'd0)) ? {1'b0, m_bytes, 3'b000} : 6'd32;
        len64 = 64'(bitcnt_q);
        if (mpend_q) begin
            pad_word = 32'h8000_0000;
        end else if (final_q && (widx_q == 4'd14)) begin
            pad_word = len64[63:32];
        end else if (final_q && (widx_q == 4'd15)) begin
            pad_word = len64[31:0];
        end else begin
            pad_word = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        bitcnt_d    = bitcnt_q;
        first_d     = first_q;
        done_d      = done_q;
        extra_d     = extra_q;
        mpend_d     = mpend_q;
        final_d     = final_q;
        wbuf_d      = wbuf_q;
        w_vld_d     = 1'b0;
        w_cnt_d     = '0;
        w_data_d    = '0;
        blk_first_d = 1'b0;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (xfer) begin
                    if (state_q == S_IDLE) begin
                        first_d  = 1'b1;
                        done_d   = 1'b0;
                        extra_d  = 1'b0;
                        bitcnt_d = LEN_W'(amt);
                    end else begin
                        bitcnt_d = bitcnt_q + LEN_W'(amt);
                    end
                    wbuf_d[widx_q] = m_last ? last_word : m_data;
                    widx_d = widx_q + 4'd1;
                    if (m_last) begin
                        done_d  = 1'b1;
                        mpend_d = (m_bytes == 2'd0);
                        if (widx_q == 4'd15) begin
                            // No room for the length: marker (if any) and length go to an extra block
                            state_d = S_SEND;
                            extra_d = 1'b1;
                        end else begin
                            state_d = S_PAD;
                            final_d = (m_bytes == 2'd0) ? (widx_q <= 4'd12) : (widx_q <= 4'd13);
                        end
                    end else if (widx_q == 4'd15) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_PAD: begin
                wbuf_d[widx_q] = pad_word;
                mpend_d = 1'b0;
                widx_d  = widx_q + 4'd1;
                if (widx_q == 4'd15) begin
                    state_d = S_SEND;
                    if (!final_q) begin
                        extra_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (w_cnt_q == 6'd63) begin
                    state_d = S_WAIT;
                end else begin
                    w_vld_d     = 1'b1;
                    w_cnt_d     = w_cnt_q + 6'd1;
                    w_data_d    = (w_cnt_q < 6'd15) ? wbuf_q[4'(w_cnt_q + 6'd1)] : '0;
                    blk_first_d = first_q;
                end
            end
            S_WAIT: begin
                first_d = 1'b0;
                if (hash_done) begin
                    widx_d = '0;
                    if (!done_q) begin
                        state_d = S_LOAD;
                    end else if (extra_q) begin
                        state_d = S_PAD;
                        final_d = 1'b1;
                        extra_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                widx_d  = '0;
            end
        endcase

        // First sweep slot is launched on the same edge that completes the buffer
        if ((state_d == S_SEND) && (state_q != S_SEND)) begin
            w_vld_d     = 1'b1;
            w_cnt_d     = '0;
            w_data_d    = wbuf_d[0];
            blk_first_d = first_d;
        end

        m_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            widx_q      <= '0;
            bitcnt_q    <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
            extra_q     <= 1'b0;
            mpend_q     <= 1'b0;
            final_q     <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                wbuf_q[i] <= '0;
            end
            m_ready_q   <= 1'b0;
            w_vld_q     <= 1'b0;
            w_cnt_q     <= '0;
            w_data_q    <= '0;
            blk_first_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            bitcnt_q    <= bitcnt_d;
            first_q     <= first_d;
            done_q      <= done_d;
            extra_q     <= extra_d;
            mpend_q     <= mpend_d;
            final_q     <= final_d;
            for (int i = 0; i < NWORDS; i++) begin
                wbuf_q[i] <= wbuf_d[i];
            end
            m_ready_q   <= m_ready_d;
            w_vld_q     <= w_vld_d;
            w_cnt_q     <= w_cnt_d;
            w_data_q    <= w_data_d;
            blk_first_q <= blk_first_d;
            busy_q      <= busy_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign w_vld     = w_vld_q;
    assign w_cnt     = w_cnt_q;
    assign w_data    = w_data_q;
    assign blk_first = blk_first_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sha256_pad_feed.sv
// Directed bench for sha256_pad_feed: hand-computed padded blocks, handshake and reset behaviour.
module tb_sha256_pad_feed;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [1:0]  m_bytes;
    logic        hash_done;
    logic        w_vld;
    logic [5:0]  w_cnt;
    logic [31:0] w_data;
    logic        blk_first;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_w [64];

    always #5 clk = ~clk;

    sha256_pad_feed #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .m_bytes(m_bytes), .hash_done(hash_done),
        .w_vld(w_vld), .w_cnt(w_cnt), .w_data(w_data), .blk_first(blk_first), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clr_exp();
        for (int i = 0; i < 64; i++) exp_w[i] = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] b);
        int n;
        m_valid = 1'b1; m_data = d; m_last = l; m_bytes = b;
        n = 0;
        while (!m_ready && n < 200) begin step(); n++; end
        chk("accept_wait", 64'(m_ready), 64'd1);
        step();
    endtask

    task automatic pulse_done();
        hash_done = 1'b1;
        step();
        hash_done = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!w_vld && n < 40) begin step(); n++; end
        chk({tag, " start"}, 64'(w_vld), 64'd1);
    endtask

    // Check all 64 slots of a sweep; optionally pulse hash_done at slot hd_at
    task automatic sweep(input string tag, input logic first, input int hd_at);
        wait_vld(tag);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("%s slot%0d", tag, i),
                64'({w_vld, m_ready, blk_first, w_cnt, w_data}),
                64'({1'b1, 1'b0, first, 6'(i), exp_w[i]}));
            if (i == hd_at) hash_done = 1'b1;
            step();
            hash_done = 1'b0;
        end
        chk({tag, " wait_entry"}, 64'({w_vld, w_cnt, m_ready, busy}), 64'({1'b0, 6'd0, 1'b0, 1'b1}));
    endtask

    initial begin
        reset_n = 1'b0; m_valid = 1'b0; m_data = '0; m_last = 1'b0; m_bytes = '0; hash_done = 1'b0;
        repeat (3) step();
        chk("reset_outs", 64'({m_ready, w_vld, w_cnt, w_data, blk_first, busy}), 64'd0);
        reset_n = 1'b1;
        step();
        chk("idle", 64'({m_ready, busy}), 64'b10);

        // "abc"
        send_word(32'h6162_6300, 1'b1, 2'd3);
        m_valid = 1'b0;
        chk("abc_pad_ready", 64'({m_ready, busy}), 64'b01);
        clr_exp(); exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
        sweep("abc", 1'b1, -1);
        repeat (4) step();
        chk("abc_hold", 64'({w_vld, m_ready, busy}), 64'b001);
        pulse_done();
        chk("abc_idle", 64'({m_ready, busy}), 64'b10);

        // 14 words, marker at 14, length in an extra block
        for (int i = 0; i < 14; i++) send_word(32'hA000_0000 | 32'(i), (i == 13), 2'd0);
        m_valid = 1'b0;
        clr_exp();
        for (int i = 0; i < 14; i++) exp_w[i] = 32'hA000_0000 | 32'(i);
        exp_w[14] = 32'h8000_0000;
        sweep("w14_b1", 1'b1, -1);
        pulse_done();
        chk("w14_no_load", 64'({m_ready, busy}), 64'b01);
        clr_exp(); exp_w[15] = 32'h0000_01C0;
        sweep("w14_b2", 1'b0, -1);
        pulse_done();
        chk("w14_idle", 64'({m_ready, busy}), 64'b10);

        // 16 full words, marker deferred to the extra block
        for (int i = 0; i < 16; i++) send_word(32'h5A00_0000 | 32'(i), (i == 15), 2'd0);
        m_valid = 1'b0;
        clr_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h5A00_0000 | 32'(i);
        sweep("w16_b1", 1'b1, -1);
        pulse_done();
        clr_exp(); exp_w[0] = 32'h8000_0000; exp_w[15] = 32'h0000_0200;
        sweep("w16_b2", 1'b0, -1);
        pulse_done();
        chk("w16_idle", 64'({m_ready, busy}), 64'b10);

        // Back-pressure: valid held while the next message's first word waits
        send_word(32'h1122_3344, 1'b0, 2'd0);
        send_word(32'h5566_7788, 1'b1, 2'd2);
        m_data = 32'hDEAD_BEEF; m_last = 1'b1; m_bytes = 2'd1;
        chk("bp_pad_ready", 64'(m_ready), 64'd0);
        clr_exp(); exp_w[0] = 32'h1122_3344; exp_w[1] = 32'h5566_8000; exp_w[15] = 32'h0000_0030;
        sweep("bp_a", 1'b1, -1);
        repeat (3) step();
        chk("bp_wait_ready", 64'({m_ready, busy}), 64'b01);
        pulse_done();
        chk("bp_idle_gap", 64'({m_ready, busy}), 64'b10);
        send_word(32'hDEAD_BEEF, 1'b1, 2'd1);
        m_valid = 1'b0;
        clr_exp(); exp_w[0] = 32'hDE80_0000; exp_w[15] = 32'h0000_0008;
        sweep("bp_b", 1'b1, -1);
        pulse_done();
        chk("bp_idle", 64'({m_ready, busy}), 64'b10);

        // hash_done during SEND is ignored
        send_word(32'h1234_5678, 1'b1, 2'd0);
        m_valid = 1'b0;
        clr_exp(); exp_w[0] = 32'h1234_5678; exp_w[1] = 32'h8000_0000; exp_w[15] = 32'h0000_0020;
        sweep("hd", 1'b1, 30);
        repeat (5) step();
        chk("hd_ignored", 64'({w_vld, m_ready, busy}), 64'b001);
        pulse_done();
        chk("hd_idle", 64'({m_ready, busy}), 64'b10);

        // Asynchronous reset in the middle of a sweep
        send_word(32'hCAFE_BABE, 1'b1, 2'd0);
        m_valid = 1'b0;
        wait_vld("rst");
        repeat (20) step();
        chk("rst_cnt20", 64'({w_vld, w_cnt}), 64'({1'b1, 6'd20}));
        reset_n = 1'b0;
        #1;
        chk("rst_async", 64'({m_ready, w_vld, w_cnt, w_data, blk_first, busy}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rst_idle", 64'({m_ready, busy}), 64'b10);
        send_word(32'h6162_6300, 1'b1, 2'd3);
        m_valid = 1'b0;
        clr_exp(); exp_w[0] = 32'h6162_6380; exp_w[15] = 32'h0000_0018;
        sweep("after_rst", 1'b1, -1);
        pulse_done();
        chk("after_rst_idle", 64'({m_ready, busy}), 64'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
